ahb_arbiter: RTL and testbench

- Bus arbiter for the shared AHB bus sitting in front of the address decoder and its slave select outputs.
- Shares the single address/data path between up to NUM_MASTERS masters using round-robin priority.
- Keeps fixed-length bursts and locked sequences intact.
- Drives HGRANT to the masters and HMASTER to the address/write-data mux and the decoder side.

---
 rtl/ahb_pkg.sv | 13 +
 rtl/ahb_arbiter_if.sv | 13 +
 rtl/ahb_arbiter_rr_picker.sv | 22 ++
 rtl/ahb_arbiter.sv | 93 +++++++++
 tb/tb_ahb_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB transfer/burst encodings and arbiter state shared by the arbiter slice.
package ahb_pkg;
    typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_e;
    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0, HB_INCR = 3'd1, HB_WRAP4 = 3'd2, HB_INCR4 = 3'd3,
        HB_WRAP8 = 3'd4, HB_INCR8 = 3'd5, HB_WRAP16 = 3'd6, HB_INCR16 = 3'd7
    } hburst_e;
    typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_LOCKED} arb_state_e;
    // Beats per burst; 0 marks undefined-length INCR. Pairs 2..7 map to 4/8/16 via HBURST[2:1].
    function automatic logic [4:0] burst_beats(input logic [2:0] b);
        return (b == HB_SINGLE) ? 5'd1 : (b == HB_INCR) ? 5'd0 : 5'd2 << b[2:1];
    endfunction
endpackage

// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: request/grant and muxed address-phase signals between masters and the arbiter.
interface ahb_arbiter_if #(parameter int NUM_MASTERS = 3, parameter int MW = 2);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MW-1:0]          HMASTER;
    logic                   HMASTLOCK;
    modport master (output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, input HGRANT, HMASTER, HMASTLOCK);
    modport slave  (input HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, output HGRANT, HMASTER, HMASTLOCK);
endinterface

// File: rtl/ahb_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector, first requester after ptr_i with wrap-around.
module rr_picker #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] win_o,
    output logic         valid_o
);
    logic [W-1:0] idx;
    // Scan farthest-first so the nearest requester after the pointer overwrites last.
    always_comb begin
        win_o = '0;
        idx = '0;
        valid_o = |req_i;
        for (int i = N; i >= 1; i--) begin
            idx = W'((int'(ptr_i) + i) % N);
            if (req_i[idx]) win_o = idx;
        end
    end
endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter that protects fixed-length bursts and locked sequences.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = 2
) (
    input logic         HCLK,
    input logic         HRESET,
    ahb_arbiter_if.slave bus
);
    localparam logic [MW-1:0] DEF = MW'(DEFAULT_MASTER);
    arb_state_e             state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [MW-1:0]          gidx_q, gidx_d, hmaster_q, hmaster_d, win;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   mastlock_q, mastlock_d, win_valid, ap, lock_own, fixed_ns;
    logic [4:0]             beats;

    assign beats    = burst_beats(bus.HBURST);
    assign fixed_ns = bus.HTRANS == HT_NONSEQ && beats > 5'd1;
    assign lock_own = bus.HLOCK[gidx_q];

    // The owner index doubles as the round-robin pointer: it always names the last winner.
    rr_picker #(.N(NUM_MASTERS), .W(MW)) u_picker (
        .req_i  (bus.HBUSREQ),
        .ptr_i  (gidx_q),
        .win_o  (win),
        .valid_o(win_valid)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_ARB;
            cnt_q      <= '0;
            gidx_q     <= DEF;
            grant_q    <= NUM_MASTERS'(1) << DEF;
            hmaster_q  <= DEF;
            mastlock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            hmaster_q  <= hmaster_d;
            mastlock_q <= mastlock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        ap = 1'b0;
        if (bus.HREADY) begin
            if (bus.HTRANS == HT_NONSEQ) cnt_d = fixed_ns ? beats - 5'd1 : 5'd0;
            else if (bus.HTRANS == HT_SEQ && cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
            else if (bus.HTRANS == HT_IDLE && state_q == ST_BURST) cnt_d = 5'd0;
            unique case (state_q)
                ST_ARB: begin
                    ap = !fixed_ns;
                    state_d = fixed_ns ? ST_BURST : ST_ARB;
                end
                ST_BURST: begin
                    if (bus.HTRANS == HT_NONSEQ) begin
                        ap = !fixed_ns;
                        state_d = fixed_ns ? ST_BURST : ST_ARB;
                    end else if ((bus.HTRANS == HT_SEQ && cnt_q == 5'd1) || bus.HTRANS == HT_IDLE) begin
                        ap = 1'b1;
                        state_d = ST_ARB;
                    end
                end
                ST_LOCKED: begin
                    ap = !lock_own;
                    state_d = lock_own ? ST_LOCKED : ST_ARB;
                end
                default: state_d = ST_ARB;
            endcase
            if (ap && lock_own) state_d = ST_LOCKED;
        end
    end

    always_comb begin
        gidx_d = (ap && !lock_own) ? (win_valid ? win : DEF) : gidx_q;
        grant_d = NUM_MASTERS'(1) << gidx_d;
        hmaster_d = bus.HREADY ? gidx_q : hmaster_q;
        mastlock_d = bus.HREADY ? lock_own : mastlock_q;
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = hmaster_q;
    assign bus.HMASTLOCK = mastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scenario tests for ahb_arbiter with hand-computed grant/master sequences.
module tb_ahb_arbiter;
    import ahb_pkg::*;
    logic HCLK = 1'b0;
    logic HRESET = 1'b0;
    int compared = 0;
    int mismatched = 0;

    ahb_arbiter_if #(.NUM_MASTERS(3), .MW(2)) bus ();
    ahb_arbiter #(.NUM_MASTERS(3), .DEFAULT_MASTER(0), .MW(2)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

    always #5 HCLK = ~HCLK;

    // Grant must be exactly one-hot at every sample point.
    always @(negedge HCLK) begin
        compared++;
        if (!$onehot(bus.HGRANT)) begin
            mismatched++;
            $display("FAIL onehot @%0t: HGRANT=%b required exactly one bit set", $time, bus.HGRANT);
        end
    end

    task automatic drive(input logic [2:0] req, input logic [2:0] lock, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rdy);
        bus.HBUSREQ = req;
        bus.HLOCK = lock;
        bus.HTRANS = tr;
        bus.HBURST = bu;
        bus.HREADY = rdy;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        drive(3'b000, 3'b000, HT_IDLE, HB_SINGLE, 1'b1);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        drive(3'b000, 3'b000, HT_IDLE, HB_SINGLE, 1'b1);
        #1 HRESET = 1'b1;
        #2;
        compared++; if (bus.HGRANT !== 3'b001) begin mismatched++; $display("FAIL reset_grant: got %b want 001", bus.HGRANT); end
        compared++; if (bus.HMASTER !== 2'd0) begin mismatched++; $display("FAIL reset_master: got %0d want 0", bus.HMASTER); end
        compared++; if (bus.HMASTLOCK !== 1'b0) begin mismatched++; $display("FAIL reset_lock: got %b want 0", bus.HMASTLOCK); end
        tick();
        HRESET = 1'b0;
        drive(3'b010, 3'b000, HT_IDLE, HB_SINGLE, 1'b1);
        tick();
        compared++; if (bus.HGRANT !== 3'b010) begin mismatched++; $display("FAIL reset_m1_grant: got %b want 010", bus.HGRANT); end
        tick();
        compared++; if (bus.HMASTER !== 2'd1) begin mismatched++; $display("FAIL reset_m1_master: got %0d want 1", bus.HMASTER); end
        drive(3'b010, 3'b000, HT_NONSEQ, HB_INCR8, 1'b1);
        tick();
        drive(3'b110, 3'b000, HT_SEQ, HB_INCR8, 1'b1);
        tick();
        tick();
        compared++; if (bus.HGRANT !== 3'b010) begin mismatched++; $display("FAIL reset_midburst_grant: got %b want 010", bus.HGRANT); end
        #2 HRESET = 1'b1;
        #1;
        compared++; if (bus.HGRANT !== 3'b001) begin mismatched++; $display("FAIL reset_async_grant: got %b want 001", bus.HGRANT); end
        compared++; if (bus.HMASTER !== 2'd0) begin mismatched++; $display("FAIL reset_async_master: got %0d want 0", bus.HMASTER); end
        compared++; if (bus.HMASTLOCK !== 1'b0) begin mismatched++; $display("FAIL reset_async_lock: got %b want 0", bus.HMASTLOCK); end
        #2 HRESET = 1'b0;
        drive(3'b000, 3'b000, HT_IDLE, HB_SINGLE, 1'b1);
        tick();
        tick();
        compared++; if (bus.HGRANT !== 3'b001) begin mismatched++; $display("FAIL reset_idle_grant: got %b want 001", bus.HGRANT); end
        compared++; if (bus.HMASTER !== 2'd0) begin mismatched++; $display("FAIL reset_idle_master: got %0d want 0", bus.HMASTER); end
    endtask

    task automatic test_round_robin();
        logic [2:0] eg [4];
        logic [1:0] em [4];
        eg = '{3'b010, 3'b100, 3'b001, 3'b010};
        em = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        drive(3'b111, 3'b000, HT_NONSEQ, HB_SINGLE, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++; if (bus.HGRANT !== eg[i]) begin mismatched++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.HGRANT, eg[i]); end
            compared++; if (bus.HMASTER !== em[i]) begin mismatched++; $display("FAIL rr_master[%0d]: got %0d want %0d", i, bus.HMASTER, em[i]); end
        end
        bus.HREADY = 1'b0;
        tick();
        compared++; if (bus.HGRANT !== 3'b010) begin mismatched++; $display("FAIL rr_wait_grant: got %b want 010", bus.HGRANT); end
        compared++; if (bus.HMASTER !== 2'd0) begin mismatched++; $display("FAIL rr_wait_master: got %0d want 0", bus.HMASTER); end
        bus.HREADY = 1'b1;
        tick();
        compared++; if (bus.HGRANT !== 3'b100) begin mismatched++; $display("FAIL rr_resume_grant: got %b want 100", bus.HGRANT); end
        compared++; if (bus.HMASTER !== 2'd1) begin mismatched++; $display("FAIL rr_resume_master: got %0d want 1", bus.HMASTER); end
    endtask

    task automatic test_burst();
        logic [1:0] tr [9];
        logic       rd [9];
        do_reset();
        drive(3'b010, 3'b000, HT_IDLE, HB_SINGLE, 1'b1);
        tick();
        drive(3'b110, 3'b000, HT_NONSEQ, HB_INCR4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if (bus.HGRANT !== ((i == 3) ? 3'b100 : 3'b010)) begin
                mismatched++;
                $display("FAIL burst_grant[%0d]: got %b want %b", i, bus.HGRANT, (i == 3) ? 3'b100 : 3'b010);
            end
            bus.HTRANS = HT_SEQ;
        end
        compared++; if (bus.HMASTER !== 2'd1) begin mismatched++; $display("FAIL burst_master_last: got %0d want 1", bus.HMASTER); end
        bus.HTRANS = HT_IDLE;
        tick();
        compared++; if (bus.HMASTER !== 2'd2) begin mismatched++; $display("FAIL burst_master_next: got %0d want 2", bus.HMASTER); end
        tr = '{HT_NONSEQ, HT_BUSY, HT_SEQ, HT_SEQ, HT_SEQ, HT_BUSY, HT_SEQ, HT_SEQ, HT_SEQ};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        drive(3'b010, 3'b000, HT_IDLE, HB_SINGLE, 1'b1);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(3'b110, 3'b000, tr[i], HB_INCR4, rd[i]);
            tick();
            compared++;
            if (bus.HGRANT !== ((i == 8) ? 3'b100 : 3'b010)) begin
                mismatched++;
                $display("FAIL burst_stall_grant[%0d]: got %b want %b", i, bus.HGRANT, (i == 8) ? 3'b100 : 3'b010);
            end
        end
    endtask

    task automatic test_early_term();
        do_reset();
        drive(3'b101, 3'b000, HT_NONSEQ, HB_WRAP8, 1'b1);
        tick();
        bus.HTRANS = HT_SEQ;
        tick();
        tick();
        compared++; if (bus.HGRANT !== 3'b001) begin mismatched++; $display("FAIL early_hold: got %b want 001", bus.HGRANT); end
        bus.HTRANS = HT_IDLE;
        tick();
        compared++; if (bus.HGRANT !== 3'b100) begin mismatched++; $display("FAIL early_grant: got %b want 100", bus.HGRANT); end
        drive(3'b001, 3'b000, HT_BUSY, HB_WRAP8, 1'b1);
        tick();
        compared++; if (bus.HGRANT !== 3'b001) begin mismatched++; $display("FAIL early_arb_state: got %b want 001", bus.HGRANT); end
    endtask

    task automatic test_lock();
        do_reset();
        drive(3'b100, 3'b100, HT_NONSEQ, HB_SINGLE, 1'b1);
        tick();
        compared++; if (bus.HGRANT !== 3'b100) begin mismatched++; $display("FAIL lock_acquire: got %b want 100", bus.HGRANT); end
        bus.HBUSREQ = 3'b111;
        for (int i = 0; i < 5; i++) begin
            tick();
            compared++; if (bus.HGRANT !== 3'b100) begin mismatched++; $display("FAIL lock_grant[%0d]: got %b want 100", i, bus.HGRANT); end
            compared++; if (bus.HMASTLOCK !== 1'b1) begin mismatched++; $display("FAIL lock_mastlock[%0d]: got %b want 1", i, bus.HMASTLOCK); end
        end
        drive(3'b011, 3'b000, HT_NONSEQ, HB_SINGLE, 1'b1);
        tick();
        compared++; if (bus.HGRANT !== 3'b001) begin mismatched++; $display("FAIL lock_release_grant: got %b want 001", bus.HGRANT); end
        tick();
        compared++; if (bus.HMASTLOCK !== 1'b0) begin mismatched++; $display("FAIL lock_release_mastlock: got %b want 0", bus.HMASTLOCK); end
        compared++; if (bus.HMASTER !== 2'd0) begin mismatched++; $display("FAIL lock_release_master: got %0d want 0", bus.HMASTER); end
    endtask

    task automatic test_no_req();
        do_reset();
        drive(3'b010, 3'b000, HT_IDLE, HB_SINGLE, 1'b1);
        tick();
        compared++; if (bus.HGRANT !== 3'b010) begin mismatched++; $display("FAIL noreq_own: got %b want 010", bus.HGRANT); end
        bus.HBUSREQ = 3'b000;
        tick();
        compared++; if (bus.HGRANT !== 3'b001) begin mismatched++; $display("FAIL noreq_default: got %b want 001", bus.HGRANT); end
        drive(3'b010, 3'b000, HT_IDLE, HB_SINGLE, 1'b1);
        tick();
        drive(3'b000, 3'b000, HT_NONSEQ, HB_INCR4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if (bus.HGRANT !== ((i == 3) ? 3'b001 : 3'b010)) begin
                mismatched++;
                $display("FAIL noreq_burst[%0d]: got %b want %b", i, bus.HGRANT, (i == 3) ? 3'b001 : 3'b010);
            end
            bus.HTRANS = HT_SEQ;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_early_term();
        test_lock();
        test_no_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
